// File: rtl/ipmi_rst_seq_if.sv
// Signal bundle between the IPMI button filter / BMC and the reset sequencer.
// The sequencer connects through the slave modport; the stimulus side uses master.
interface ipmi_rst_seq_if;
  logic       ipmi_btn_press;
  logic       bmc_ready;
  logic       bmc_rst_n;
  logic       busy;
  logic       rst_done;
  logic       rst_timeout;
  logic [7:0] rst_cnt;

  modport master (
    output ipmi_btn_press,
    output bmc_ready,
    input  bmc_rst_n,
    input  busy,
    input  rst_done,
    input  rst_timeout,
    input  rst_cnt
  );

  modport slave (
    input  ipmi_btn_press,
    input  bmc_ready,
    output bmc_rst_n,
    output busy,
    output rst_done,
    output rst_timeout,
    output rst_cnt
  );
endinterface

// File: rtl/ipmi_rst_seq.sv
// Turns each new filtered IPMI press into one timed BMC reset, waits for ready, then locks out.
// Define IPMI_RST_CNT_EN to build the saturating reset-event counter on rst_cnt.
module ipmi_rst_seq #(
  parameter int RST_LOW_CYC    = 3277,
  parameter int READY_WAIT_CYC = 16384,
  parameter int LOCKOUT_CYC    = 32768
) (
  input  logic          i_clk_32k,
  input  logic          i_rst_n,
  ipmi_rst_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ASSERT   = 2'd1,
    S_WAIT_RDY = 2'd2,
    S_LOCKOUT  = 2'd3
  } state_t;

  localparam logic [15:0] RST_LAST  = 16'(RST_LOW_CYC - 1);
  localparam logic [15:0] WAIT_LAST = 16'(READY_WAIT_CYC - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCKOUT_CYC - 1);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        press_prev_reg;
  logic        rdy_meta_reg, rdy_s_reg;
  logic        bmc_rst_n_reg, busy_reg, rst_done_reg, rst_timeout_reg;
  logic        done_next, timeout_next;
  logic        press_rise;

  assign press_rise = bus.ipmi_btn_press & ~press_prev_reg;

  // Outputs are registered from next-state so they change on the same edge as the state.
  always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= '0;
      press_prev_reg  <= 1'b0;
      rdy_meta_reg    <= 1'b0;
      rdy_s_reg       <= 1'b0;
      bmc_rst_n_reg   <= 1'b1;
      busy_reg        <= 1'b0;
      rst_done_reg    <= 1'b0;
      rst_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      press_prev_reg  <= bus.ipmi_btn_press;
      rdy_meta_reg    <= bus.bmc_ready;
      rdy_s_reg       <= rdy_meta_reg;
      bmc_rst_n_reg   <= (state_next != S_ASSERT);
      busy_reg        <= (state_next != S_IDLE);
      rst_done_reg    <= done_next;
      rst_timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    done_next    = 1'b0;
    timeout_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (press_rise) state_next = S_ASSERT;
      end
      S_ASSERT: begin
        if (cnt_reg == RST_LAST) state_next = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        // Ready has priority over expiry in the same cycle.
        if (rdy_s_reg) begin
          done_next  = 1'b1;
          state_next = S_LOCKOUT;
        end else if (cnt_reg == WAIT_LAST) begin
          timeout_next = 1'b1;
          state_next   = S_LOCKOUT;
        end
      end
      S_LOCKOUT: begin
        if ((cnt_reg >= LOCK_LAST) && !bus.ipmi_btn_press) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Cleared on every state change, saturating count while sequencing.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_next != state_reg) begin
      cnt_next = '0;
    end else if ((state_reg != S_IDLE) && (cnt_reg != 16'hFFFF)) begin
      cnt_next = cnt_reg + 16'd1;
    end
  end

  assign bus.bmc_rst_n   = bmc_rst_n_reg;
  assign bus.busy        = busy_reg;
  assign bus.rst_done    = rst_done_reg;
  assign bus.rst_timeout = rst_timeout_reg;

`ifdef IPMI_RST_CNT_EN
  logic [7:0] rst_cnt_reg;

  always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_cnt_reg <= '0;
    end else if ((state_reg == S_IDLE) && (state_next == S_ASSERT) && (rst_cnt_reg != 8'hFF)) begin
      rst_cnt_reg <= rst_cnt_reg + 8'd1;
    end
  end

  assign bus.rst_cnt = rst_cnt_reg;
`else
  assign bus.rst_cnt = 8'h00;
`endif

endmodule
